// File: rtl/spi_adc_sequencer.sv
// spi_adc_sequencer: round-robin scan of enabled ADC channels over the engine's simple bus,
// tagged samples buffered in a first-word-fall-through FIFO
module spi_adc_sequencer #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH = 4,
  parameter int FIFO_DEPTH = 16,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  start,
  input  logic                  stop,
  input  logic [4:0]            cfg_ndb,
  input  logic [14:0]           cfg_rate,
  input  logic [NUM_CH-1:0]     ch_mask,
  output logic                  spi_wr,
  output logic [ADDR_WIDTH-1:0] spi_wrAddr,
  output logic [DATA_WIDTH-1:0] spi_wrData,
  output logic                  spi_rd,
  input  logic [DATA_WIDTH-1:0] spi_rdData,
  output logic                  smp_valid,
  input  logic                  smp_ready,
  output logic [23:0]           smp_data,
  output logic [CH_W-1:0]       smp_ch,
  output logic                  busy,
  output logic                  overflow,
  output logic                  timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, SETUP, CMD, POLL, READ, STOP} state_e;
  state_e state_q, state_d;
  logic [NUM_CH-1:0] mask_q;
  logic [4:0] ndb_q;
  logic [14:0] rate_q;
  logic [CH_W-1:0] ptr_q, ptr_d, ptr_first, tag_nxt_q, tag_cur_q, j;
  logic [16:0] wd_q;
  logic discard_q, ovf_q, to_q;
  logic start_ok, fresh, wd_hit, to_set, push, pop, full, wen, drop;
  logic [24:0] smask;
  logic [23:0] sample;
  logic [CH_W+23:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic unused;
  assign start_ok = start && (ch_mask != '0);
  assign fresh = spi_rdData[30];
  assign wd_hit = (wd_q + 17'd1) == {1'b0, rate_q, 1'b0};
  assign to_set = state_q == POLL && !fresh && wd_hit && !stop;
  assign smask = (25'd1 << ndb_q) - 25'd1;
  assign sample = spi_rdData[23:0] & smask[23:0];
  // a stop seen during READ still completes the strobe but drops the sample
  assign push = state_q == READ && !discard_q && !stop;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign pop = smp_ready && smp_valid;
  assign wen = push && (!full || pop);
  assign drop = push && full && !pop;
  assign unused = ^{spi_rdData[DATA_WIDTH-1:31], spi_rdData[29:24], smask[24]};
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_ok ? SETUP : IDLE;
      SETUP:   state_d = CMD;
      CMD:     state_d = POLL;
      POLL:    state_d = fresh ? READ : wd_hit ? STOP : POLL;
      READ:    state_d = CMD;
      default: state_d = IDLE;
    endcase
    if (stop && state_q != IDLE && state_q != STOP) state_d = STOP;
  end
  always_comb begin
    spi_wr = state_q inside {SETUP, CMD, STOP};
    spi_rd = state_q == READ;
    spi_wrAddr = (state_q == STOP) ? ADDR_WIDTH'(4) : '0;
    spi_wrData = (state_q == SETUP) ? DATA_WIDTH'({rate_q, ndb_q})
               : (state_q == CMD) ? DATA_WIDTH'(ptr_q) << (ndb_q - 5'(CH_W)) : '0;
  end
  assign busy = state_q != IDLE;
  assign overflow = ovf_q;
  assign timeout = to_q;
  // lowest enabled channel at start, then next enabled channel after ptr with wrap
  always_comb begin
    ptr_first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) ptr_first = ch_mask[i] ? CH_W'(i) : ptr_first;
    ptr_d = ptr_q;
    j = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      j = CH_W'((int'(ptr_q) + i) % NUM_CH);
      ptr_d = mask_q[j] ? j : ptr_d;
    end
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      mask_q <= '0;
      ndb_q <= '0;
      rate_q <= '0;
      ptr_q <= '0;
      tag_nxt_q <= '0;
      tag_cur_q <= '0;
      wd_q <= '0;
      discard_q <= 1'b0;
      ovf_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start_ok) begin
        mask_q <= ch_mask;
        ndb_q <= cfg_ndb;
        rate_q <= cfg_rate;
        ptr_q <= ptr_first;
        wd_q <= '0;
        discard_q <= 1'b1;
        ovf_q <= 1'b0;
        to_q <= 1'b0;
      end else begin
        ovf_q <= ovf_q || drop;
        to_q <= to_q || to_set;
      end
      if (state_q == CMD) begin
        tag_nxt_q <= ptr_q;
        ptr_q <= ptr_d;
      end
      if (state_q == POLL) wd_q <= wd_q + 17'd1;
      // the ADC answers with the previous frame's command, hence the one-frame tag lag
      if (state_q == READ) begin
        wd_q <= '0;
        tag_cur_q <= tag_nxt_q;
        discard_q <= 1'b0;
      end
    end
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wen) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(wen) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (wen) mem[wp_q] <= {tag_cur_q, sample};
  end
  assign smp_valid = cnt_q != '0;
  assign {smp_ch, smp_data} = smp_valid ? mem[rp_q] : '0;
endmodule
